// File: rtl/dbus_arbiter_if.sv
// Signal bundle between the two data-bus masters, the arbiter and the shared slave bus.
interface dbus_arbiter_if #(
    parameter int unsigned DBITS = 32
);
    logic             m0_req;
    logic             m0_lock;
    logic [DBITS-1:0] m0_addr;
    logic             m0_wren;
    logic [DBITS-1:0] m0_wdata;
    logic             m0_gnt;
    logic             m0_ack;
    logic [DBITS-1:0] m0_rdata;

    logic             m1_req;
    logic             m1_lock;
    logic [DBITS-1:0] m1_addr;
    logic             m1_wren;
    logic [DBITS-1:0] m1_wdata;
    logic             m1_gnt;
    logic             m1_ack;
    logic [DBITS-1:0] m1_rdata;

    logic [DBITS-1:0] abus;
    logic             wren;
    logic [DBITS-1:0] dbus_out;
    logic [DBITS-1:0] dbus_in;

    // Arbiter side
    modport slave (
        input  m0_req, m0_lock, m0_addr, m0_wren, m0_wdata,
        input  m1_req, m1_lock, m1_addr, m1_wren, m1_wdata,
        input  dbus_in,
        output m0_gnt, m0_ack, m0_rdata,
        output m1_gnt, m1_ack, m1_rdata,
        output abus, wren, dbus_out
    );

    // Masters plus bus environment side
    modport master (
        output m0_req, m0_lock, m0_addr, m0_wren, m0_wdata,
        output m1_req, m1_lock, m1_addr, m1_wren, m1_wdata,
        output dbus_in,
        input  m0_gnt, m0_ack, m0_rdata,
        input  m1_gnt, m1_ack, m1_rdata,
        input  abus, wren, dbus_out
    );
endinterface

// File: rtl/dbus_arbiter.sv
// Two-master round-robin data-bus arbiter with beat-limit pre-emption and owner lock.
// Muxes the owner's address/write data onto the shared bus and returns read data.
module dbus_arbiter #(
    parameter int unsigned DBITS    = 32,
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic          clk,
    input  logic          reset,
    dbus_arbiter_if.slave bus
);
    localparam int unsigned CW = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_last_owner;
    logic [CW-1:0]    r_beat_cnt;
    logic             r_m0_gnt;
    logic             r_m1_gnt;
    logic             r_m0_ack;
    logic             r_m1_ack;
    logic [DBITS-1:0] r_m0_rdata;
    logic [DBITS-1:0] r_m1_rdata;

    logic             w_beat0;
    logic             w_beat1;
    logic [CW-1:0]    w_cnt_inc;
    logic             w_hit_max;

    assign w_beat0   = r_m0_gnt & bus.m0_req;
    assign w_beat1   = r_m1_gnt & bus.m1_req;
    assign w_cnt_inc = (r_beat_cnt == CNT_MAX) ? CNT_MAX : r_beat_cnt + CW'(1);
    // True when the beat in flight brings the owner to its limit (or it is already saturated)
    assign w_hit_max = (w_cnt_inc == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.m0_req && bus.m1_req) w_next = r_last_owner ? OWN0 : OWN1;
                else if (bus.m0_req)          w_next = OWN0;
                else if (bus.m1_req)          w_next = OWN1;
            end
            OWN0: begin
                if (!bus.m0_req)                                   w_next = bus.m1_req ? OWN1 : IDLE;
                else if (w_hit_max && bus.m1_req && !bus.m0_lock) w_next = OWN1;
            end
            OWN1: begin
                if (!bus.m1_req)                                   w_next = bus.m0_req ? OWN0 : IDLE;
                else if (w_hit_max && bus.m0_req && !bus.m1_lock) w_next = OWN0;
            end
            default: w_next = IDLE;
        endcase
    end

    // Grants, beat counter, round-robin history and beat completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_owner <= 1'b1;
            r_beat_cnt   <= '0;
            r_m0_gnt     <= 1'b0;
            r_m1_gnt     <= 1'b0;
            r_m0_ack     <= 1'b0;
            r_m1_ack     <= 1'b0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
        end else begin
            r_m0_gnt <= (w_next == OWN0);
            r_m1_gnt <= (w_next == OWN1);

            if (w_next != r_state)      r_beat_cnt <= '0;
            else if (w_beat0 | w_beat1) r_beat_cnt <= w_cnt_inc;

            if (w_next == OWN0)      r_last_owner <= 1'b0;
            else if (w_next == OWN1) r_last_owner <= 1'b1;

            r_m0_ack <= w_beat0;
            r_m1_ack <= w_beat1;
            if (w_beat0) r_m0_rdata <= bus.dbus_in;
            if (w_beat1) r_m1_rdata <= bus.dbus_in;
        end
    end

    // Owner drives the shared bus only during a beat
    always_comb begin
        bus.abus     = '0;
        bus.wren     = 1'b0;
        bus.dbus_out = '0;
        if (w_beat0) begin
            bus.abus     = bus.m0_addr;
            bus.wren     = bus.m0_wren;
            bus.dbus_out = bus.m0_wren ? bus.m0_wdata : '0;
        end else if (w_beat1) begin
            bus.abus     = bus.m1_addr;
            bus.wren     = bus.m1_wren;
            bus.dbus_out = bus.m1_wren ? bus.m1_wdata : '0;
        end
    end

    assign bus.m0_gnt   = r_m0_gnt;
    assign bus.m1_gnt   = r_m1_gnt;
    assign bus.m0_ack   = r_m0_ack;
    assign bus.m1_ack   = r_m1_ack;
    assign bus.m0_rdata = r_m0_rdata;
    assign bus.m1_rdata = r_m1_rdata;
endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: directed scenarios then random traffic, all checked against an
// ownership/streak reference model.
module tb_dbus_arbiter;
    localparam int unsigned DBITS    = 32;
    localparam int          HOLD_MAX = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dbus_arbiter_if #(.DBITS(DBITS)) bus ();

    dbus_arbiter #(.DBITS(DBITS), .HOLD_MAX(HOLD_MAX)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: owner -1 = nobody, streak = beats since this ownership began
    int          mo_owner;
    int          mo_streak;
    int          mo_last;
    logic        mo_ack   [2];
    logic [31:0] mo_rdata [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mo_owner    = -1;
        mo_streak   = 0;
        mo_last     = 1;
        mo_ack[0]   = 1'b0;
        mo_ack[1]   = 1'b0;
        mo_rdata[0] = '0;
        mo_rdata[1] = '0;
    endtask

    task automatic model_edge();
        logic req [2];
        logic lock[2];
        bit   beat;
        int   nxt;
        int   o;
        req[0]  = bus.m0_req;  req[1]  = bus.m1_req;
        lock[0] = bus.m0_lock; lock[1] = bus.m1_lock;
        beat = 1'b0;
        if (mo_owner >= 0) beat = req[mo_owner];
        for (int x = 0; x < 2; x++) begin
            mo_ack[x] = beat && (mo_owner == x);
            if (mo_ack[x]) mo_rdata[x] = bus.dbus_in;
        end
        nxt = mo_owner;
        if (mo_owner < 0) begin
            if (req[0] && req[1]) nxt = 1 - mo_last;
            else if (req[0])      nxt = 0;
            else if (req[1])      nxt = 1;
        end else begin
            o = mo_owner;
            if (!req[o])                                                    nxt = req[1-o] ? 1 - o : -1;
            else if ((mo_streak + 1 >= HOLD_MAX) && req[1-o] && !lock[o])   nxt = 1 - o;
        end
        if (nxt != mo_owner) begin
            mo_streak = 0;
            if (nxt >= 0) mo_last = nxt;
        end else if (beat) begin
            mo_streak++;
        end
        mo_owner = nxt;
    endtask

    task automatic check_regs();
        chk("m0_gnt",   32'(bus.m0_gnt),   32'(mo_owner == 0));
        chk("m1_gnt",   32'(bus.m1_gnt),   32'(mo_owner == 1));
        chk("m0_ack",   32'(bus.m0_ack),   32'(mo_ack[0]));
        chk("m1_ack",   32'(bus.m1_ack),   32'(mo_ack[1]));
        chk("m0_rdata", bus.m0_rdata,      mo_rdata[0]);
        chk("m1_rdata", bus.m1_rdata,      mo_rdata[1]);
    endtask

    task automatic check_bus();
        logic [31:0] e_abus, e_dout;
        logic        e_wren;
        e_abus = '0; e_dout = '0; e_wren = 1'b0;
        if (mo_owner == 0 && bus.m0_req) begin
            e_abus = bus.m0_addr; e_wren = bus.m0_wren;
            e_dout = bus.m0_wren ? bus.m0_wdata : 32'h0;
        end else if (mo_owner == 1 && bus.m1_req) begin
            e_abus = bus.m1_addr; e_wren = bus.m1_wren;
            e_dout = bus.m1_wren ? bus.m1_wdata : 32'h0;
        end
        chk("abus",     bus.abus,        e_abus);
        chk("wren",     32'(bus.wren),   32'(e_wren));
        chk("dbus_out", bus.dbus_out,    e_dout);
    endtask

    // Called just after an edge: settle, check bus, take the edge, check registered outputs
    task automatic cycle();
        #1;
        check_bus();
        @(posedge clk);
        model_edge();
        #1;
        check_regs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_regs();
        check_bus();
        reset = 1'b0;
    endtask

    task automatic set_m(input int x, input logic req, input logic lock, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (x == 0) begin
            bus.m0_req = req; bus.m0_lock = lock; bus.m0_wren = wr;
            bus.m0_addr = addr; bus.m0_wdata = wdata;
        end else begin
            bus.m1_req = req; bus.m1_lock = lock; bus.m1_wren = wr;
            bus.m1_addr = addr; bus.m1_wdata = wdata;
        end
    endtask

    initial begin
        int n0;
        reset = 1'b1;
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        bus.dbus_in = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_regs();
        reset = 1'b0;

        // Reset in the middle of an m0 write beat
        set_m(0, 1'b1, 1'b0, 1'b1, 32'h0000_1000, 32'hCAFE_0001);
        bus.dbus_in = 32'h1111_2222;
        cycle();
        cycle();
        chk("t1_wren_before", 32'(bus.wren), 32'd1);
        do_reset();
        chk("t1_gnt0_after", 32'(bus.m0_gnt), 32'd0);
        chk("t1_wren_after", 32'(bus.wren),   32'd0);
        chk("t1_ack0_after", 32'(bus.m0_ack), 32'd0);
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle();
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h0000_2000, 32'h0);
        cycle();
        chk("t1_resume_gnt0", 32'(bus.m0_gnt), 32'd1);
        cycle();
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle();

        // Simultaneous request after reset: m0 wins, then hands over on release
        do_reset();
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        cycle();
        chk("t2_gnt0", 32'(bus.m0_gnt), 32'd1);
        chk("t2_gnt1", 32'(bus.m1_gnt), 32'd0);
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle();
        chk("t2_handover_gnt1", 32'(bus.m1_gnt), 32'd1);
        chk("t2_handover_gnt0", 32'(bus.m0_gnt), 32'd0);
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle();

        // Beat limit pre-emption, both directions
        do_reset();
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h30, 32'h0);
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        cycle();
        n0 = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.m0_gnt) n0++;
            bus.dbus_in = $urandom;
            cycle();
        end
        chk("t3_m0_beats", 32'(n0), 32'd8);
        chk("t3_pre_gnt1", 32'(bus.m1_gnt), 32'd1);
        chk("t3_pre_gnt0", 32'(bus.m0_gnt), 32'd0);
        for (int i = 0; i < 8; i++) cycle();
        chk("t3_back_gnt0", 32'(bus.m0_gnt), 32'd1);
        for (int i = 0; i < 3; i++) cycle();
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle();

        // Lock holds off pre-emption; release switches at the next edge
        do_reset();
        set_m(0, 1'b1, 1'b1, 1'b1, 32'h50, 32'h5555);
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h60, 32'h0);
        cycle();
        for (int i = 0; i < 15; i++) begin
            cycle();
            chk("t4_starved_gnt1", 32'(bus.m1_gnt), 32'd0);
        end
        bus.m0_lock = 1'b0;
        cycle();
        chk("t4_unlock_gnt1", 32'(bus.m1_gnt), 32'd1);
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle();

        // m1 read returns slave data
        do_reset();
        set_m(1, 1'b1, 1'b0, 1'b0, 32'hF000_0014, 32'h0);
        bus.dbus_in = 32'h0000_03A5;
        cycle();
        chk("t5_gnt1", 32'(bus.m1_gnt), 32'd1);
        cycle();
        chk("t5_ack1",   32'(bus.m1_ack), 32'd1);
        chk("t5_rdata1", bus.m1_rdata,    32'h0000_03A5);
        chk("t5_ack0",   32'(bus.m0_ack), 32'd0);
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle();

        // m0 write drives the shared bus in the same cycle; reads drive no data
        set_m(0, 1'b1, 1'b0, 1'b1, 32'hF000_0000, 32'h0000_1234);
        cycle();
        #1;
        chk("t6_abus",     bus.abus,          32'hF000_0000);
        chk("t6_wren",     32'(bus.wren),     32'd1);
        chk("t6_dbus_out", bus.dbus_out,      32'h0000_1234);
        bus.m0_wren = 1'b0;
        #1;
        chk("t6_read_dout", bus.dbus_out,     32'h0);
        chk("t6_read_wren", 32'(bus.wren),    32'd0);
        cycle();
        set_m(0, 1'b0, 1'b0, 1'b1, 32'hF000_0000, 32'h0000_1234);
        #1;
        chk("t6_nobeat_dout", bus.dbus_out,   32'h0);
        cycle();

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            set_m(0, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 20, 1'($urandom),
                  $urandom, $urandom);
            set_m(1, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 20, 1'($urandom),
                  $urandom, $urandom);
            bus.dbus_in = $urandom;
            if ($urandom_range(0, 199) == 0) do_reset();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
